// File: rtl/iobus_pkg.sv
// Shared IO bus definitions: bus widths and the timeout responder FSM encoding.
package iobus_pkg;

  localparam int unsigned IOBUS_ADDR_W = 32;
  localparam int unsigned IOBUS_DATA_W = 32;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWait    = 2'd1,
    StRespond = 2'd2
  } iobus_state_e;

endpackage

// File: rtl/iobus_timeout_responder_if.sv
// MicroBlaze IO bus signals as seen by the default-response slave.
interface iobus_timeout_responder_if;
  import iobus_pkg::*;

  logic                    io_addr_strobe;
  logic [IOBUS_ADDR_W-1:0] io_address;
  logic                    io_write_strobe;
  logic                    target_ready;
  logic [IOBUS_DATA_W-1:0] io_read_data;
  logic                    io_ready;

  modport master (
    output io_addr_strobe,
    output io_address,
    output io_write_strobe,
    output target_ready,
    input  io_read_data,
    input  io_ready
  );

  modport slave (
    input  io_addr_strobe,
    input  io_address,
    input  io_write_strobe,
    input  target_ready,
    output io_read_data,
    output io_ready
  );

endinterface

// File: rtl/iobus_sat_counter.sv
// Saturating event counter; a clear coinciding with an increment yields one.
module iobus_sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? WIDTH'(1) : '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/iobus_timeout_responder.sv
// Default responder for unclaimed IO bus accesses: answers with DEFAULT_VALUE after TIMEOUT
// cycles unless a real target responds first, and logs the offending access.
module iobus_timeout_responder
  import iobus_pkg::*;
#(
  parameter logic [IOBUS_DATA_W-1:0] DEFAULT_VALUE = 32'hffffffff,
  parameter int unsigned             TIMEOUT       = 16,
  parameter int unsigned             CNT_WIDTH     = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  iobus_timeout_responder_if.slave    bus,
  input  logic                        err_clear,
  output logic                        err_irq,
  output logic [IOBUS_ADDR_W-1:0]     err_addr,
  output logic                        err_write,
  output logic [CNT_WIDTH-1:0]        err_count
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  // The WAIT cycle whose increment reaches TIMEOUT-1 is the last one before RESPOND.
  localparam logic [CntW-1:0] WaitLast = CntW'(TIMEOUT - 2);

  iobus_state_e            state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IOBUS_ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic                    pend_write_q, pend_write_d;
  logic                    io_ready_q;
  logic [IOBUS_DATA_W-1:0] io_read_data_q;
  logic                    err_irq_q;
  logic [IOBUS_ADDR_W-1:0] err_addr_q;
  logic                    err_write_q;
  logic                    respond_entry;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_addr_d  = pend_addr_q;
    pend_write_d = pend_write_q;

    if (bus.io_addr_strobe) begin
      // A strobe always starts a fresh access, including a restart from WAIT.
      cnt_d        = '0;
      pend_addr_d  = bus.io_address;
      pend_write_d = bus.io_write_strobe;
      if (bus.target_ready) begin
        state_d = StIdle;
      end else begin
        state_d = (TIMEOUT == 1) ? StRespond : StWait;
      end
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StWait: begin
          if (bus.target_ready) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == WaitLast) begin
              state_d = StRespond;
            end
          end
        end
        StRespond: state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end

    respond_entry = (state_d == StRespond);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      pend_addr_q    <= '0;
      pend_write_q   <= 1'b0;
      io_ready_q     <= 1'b0;
      io_read_data_q <= '0;
      err_irq_q      <= 1'b0;
      err_addr_q     <= '0;
      err_write_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pend_addr_q    <= pend_addr_d;
      pend_write_q   <= pend_write_d;
      io_ready_q     <= respond_entry;
      io_read_data_q <= respond_entry ? DEFAULT_VALUE : '0;
      if (respond_entry) begin
        err_irq_q   <= 1'b1;
        err_addr_q  <= pend_addr_d;
        err_write_q <= pend_write_d;
      end else if (err_clear) begin
        err_irq_q <= 1'b0;
      end
    end
  end

  iobus_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (respond_entry),
    .clr   (err_clear),
    .count (err_count)
  );

  assign bus.io_ready     = io_ready_q;
  assign bus.io_read_data = io_read_data_q;
  assign err_irq          = err_irq_q;
  assign err_addr         = err_addr_q;
  assign err_write        = err_write_q;

endmodule

// File: tb/tb_iobus_timeout_responder.sv
// Randomised self-checking bench for iobus_timeout_responder with TIMEOUT=4.
module tb_iobus_timeout_responder;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        err_clear = 1'b0;
  logic        err_irq;
  logic [31:0] err_addr;
  logic        err_write;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  // Reference model of the error log.
  int          m_count = 0;
  bit          m_irq = 0;
  logic [31:0] m_addr = '0;
  bit          m_write = 0;

  iobus_timeout_responder_if bus ();

  iobus_timeout_responder #(
    .DEFAULT_VALUE (32'hffffffff),
    .TIMEOUT       (TO),
    .CNT_WIDTH     (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .err_clear (err_clear),
    .err_irq   (err_irq),
    .err_addr  (err_addr),
    .err_write (err_write),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.io_addr_strobe  = 1'b0;
    bus.io_address      = '0;
    bus.io_write_strobe = 1'b0;
    bus.target_ready    = 1'b0;
    err_clear           = 1'b0;
  endtask

  task automatic check_log(input string name);
    checks++;
    if (err_irq !== m_irq || err_addr !== m_addr || err_write !== m_write ||
        err_count !== 8'(m_count)) begin
      errors++;
      $display("FAIL %s: got irq=%0b addr=%h wr=%0b cnt=%0d, want irq=%0b addr=%h wr=%0b cnt=%0d",
               name, err_irq, err_addr, err_write, err_count, m_irq, m_addr, m_write, m_count);
    end
  endtask

  // One access: strobe at cycle 0, target_ready at cycle rdy (>6 = never),
  // err_clear at cycle clr (<0 = never). Checks io_ready/io_read_data each cycle.
  task automatic do_access(input logic [31:0] addr, input bit wr, input int rdy, input int clr,
                           input string name);
    bit   timed_out;
    logic exp_rdy;
    timed_out = (rdy >= int'(TO));
    bus.io_addr_strobe  = 1'b1;
    bus.io_address      = addr;
    bus.io_write_strobe = wr;
    bus.target_ready    = (rdy == 0);
    err_clear           = (clr == 0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_rdy = timed_out && (k == int'(TO));
      checks++;
      if (bus.io_ready !== exp_rdy || bus.io_read_data !== (exp_rdy ? 32'hffffffff : 32'h0)) begin
        errors++;
        $display("FAIL %s cycle %0d: got ready=%0b data=%h, want ready=%0b data=%h", name, k,
                 bus.io_ready, bus.io_read_data, exp_rdy, exp_rdy ? 32'hffffffff : 32'h0);
      end
      bus.io_addr_strobe  = 1'b0;
      bus.io_address      = '0;
      bus.io_write_strobe = 1'b0;
      bus.target_ready    = (rdy == k);
      err_clear           = (clr == k);
    end
    tick();
    idle_inputs();
    if (clr >= 0) begin
      m_count = 0;
      m_irq   = 0;
    end
    if (timed_out) begin
      // A clear before or alongside the timeout leaves only the new event counted.
      m_count = (m_count < 255) ? m_count + 1 : 255;
      m_irq   = 1;
      m_addr  = addr;
      m_write = wr;
      if (clr > int'(TO) - 1) begin
        m_count = 0;
        m_irq   = 0;
      end
    end
    check_log(name);
  endtask

  task automatic test_reset();
    idle_inputs();
    #12;
    checks++;
    if (bus.io_ready !== 1'b0 || bus.io_read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: got ready=%0b data=%h, want 0/0", bus.io_ready, bus.io_read_data);
    end
    check_log("reset_log");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_timeout_read();
    do_access(32'hC000_0010, 1'b0, 99, -1, "timeout_read");
  endtask

  task automatic test_target_wins();
    do_access(32'h1234_5678, 1'b1, 2, -1, "ready_cycle2");
    do_access(32'h2222_0000, 1'b0, 0, -1, "ready_zero_wait");
    do_access(32'h3333_0004, 1'b0, 3, -1, "ready_boundary");
    do_access(32'h4444_0008, 1'b1, 4, -1, "ready_late");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_access($urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 8)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1, "random");
    end
  endtask

  task automatic test_saturate();
    do_access(32'h0, 1'b0, 0, 0, "pre_clear");
    for (int i = 0; i < 256; i++) begin
      do_access(32'hA000_0000 + 32'(i), 1'b1, 99, -1, "sat_write");
    end
    checks++;
    if (err_count !== 8'd255 || err_write !== 1'b1) begin
      errors++;
      $display("FAIL saturate: got cnt=%0d wr=%0b, want cnt=255 wr=1", err_count, err_write);
    end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    m_count = 0;
    m_irq   = 0;
    check_log("clear_pulse");
  endtask

  task automatic test_clear_collision();
    do_access(32'hB000_0000, 1'b0, 99, -1, "pre_collision");
    do_access(32'hB000_0100, 1'b1, 99, int'(TO) - 1, "clear_collision");
    checks++;
    if (err_irq !== 1'b1 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL collision: got irq=%0b cnt=%0d, want irq=1 cnt=1", err_irq, err_count);
    end
  endtask

  // Second strobe at cycle s2: during WAIT it restarts, in RESPOND it is a new access.
  task automatic test_back_to_back(input int s2);
    logic [31:0] a1, a2;
    logic        exp_rdy;
    bit          first_ok;
    a1 = $urandom;
    a2 = $urandom;
    first_ok = (s2 >= int'(TO));
    bus.io_addr_strobe = 1'b1;
    bus.io_address     = a1;
    for (int k = 1; k <= s2 + int'(TO) + 2; k++) begin
      tick();
      exp_rdy = (first_ok && k == int'(TO)) || (k == s2 + int'(TO));
      checks++;
      if (bus.io_ready !== exp_rdy) begin
        errors++;
        $display("FAIL back_to_back s2=%0d cycle %0d: got ready=%0b, want %0b", s2, k,
                 bus.io_ready, exp_rdy);
      end
      bus.io_addr_strobe = (k == s2);
      bus.io_address     = (k == s2) ? a2 : 32'h0;
    end
    idle_inputs();
    m_count = m_count + (first_ok ? 2 : 1);
    if (m_count > 255) m_count = 255;
    m_irq   = 1;
    m_addr  = a2;
    m_write = 0;
    check_log("back_to_back_log");
  endtask

  task automatic test_reset_mid_wait();
    bus.io_addr_strobe = 1'b1;
    bus.io_address     = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    m_count = 0;
    m_irq   = 0;
    m_addr  = '0;
    m_write = 0;
    checks++;
    if (bus.io_ready !== 1'b0 || bus.io_read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_bus: got ready=%0b data=%h", bus.io_ready, bus.io_read_data);
    end
    check_log("reset_mid_log");
    #10;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (bus.io_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_release cycle %0d: got ready=%0b, want 0", k, bus.io_ready);
      end
    end
    check_log("reset_release_log");
  endtask

  initial begin
    test_reset();
    test_timeout_read();
    test_target_wins();
    test_random();
    test_saturate();
    test_clear_collision();
    test_back_to_back(2);
    test_back_to_back(4);
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iobus_timeout_responder.md
IOBUS_TIMEOUT_RESPONDER -- requirements
Module: iobus_timeout_responder

Interface
REQ-001 SHALL have parameter DEFAULT_VALUE, default 32'hffffffff: read data returned on a timed-out access.
REQ-002 SHALL have parameter TIMEOUT, default 16: cycles after the strobe before the default response; legal range 1..255.
REQ-003 SHALL have parameter CNT_WIDTH, default 8: width of the saturating error counter.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, named as the codebase does: clk, rst_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 io_addr_strobe  input  1  MicroBlaze IO bus access start, one-cycle pulse.
REQ-008 io_address  input  32  access address, valid with the strobe.
REQ-009 io_write_strobe  input  1  access is a write, valid with the strobe.
REQ-010 target_ready  input  1  OR of all real target io_ready outputs.
REQ-011 io_read_data  output  32  DEFAULT_VALUE while io_ready is high, else 0 (OR-combinable).
REQ-012 io_ready  output  1  default-response ready, one-cycle pulse.
REQ-013 err_irq  output  1  sticky timeout interrupt.
REQ-014 err_addr  output  32  address of the most recent timed-out access.
REQ-015 err_write  output  1  the most recent timed-out access was a write.
REQ-016 err_count  output  CNT_WIDTH  number of timeouts, saturating.
REQ-017 err_clear  input  1  clears err_irq and err_count.

Function
REQ-018 SHALL implement a three-state FSM: IDLE, WAIT, RESPOND.
REQ-019 IDLE, strobe high -> WAIT:
- load counter with 0;
- latch io_address and io_write_strobe into pending registers.
REQ-020 WAIT, target_ready high -> IDLE, with no response and no error logged.
REQ-021 WAIT, target_ready low -> increment counter; when counter reaches TIMEOUT-1 -> RESPOND.
REQ-022 Timing: strobe in cycle 0 -> io_ready high in cycle TIMEOUT exactly, provided target_ready stayed low in cycles 0..TIMEOUT-1.
REQ-023 RESPOND lasts one cycle, then -> IDLE. During RESPOND: io_ready=1, io_read_data=DEFAULT_VALUE, both driven from registers.
REQ-024 target_ready in the strobe cycle itself (zero-wait target) -> return to IDLE, no timeout.
REQ-025 target_ready and timeout in the same cycle -> the target wins; RESPOND SHALL NOT be entered.
REQ-026 Strobe while in WAIT (protocol violation) -> restart: counter=0, pending registers reloaded.
REQ-027 target_ready while in RESPOND -> ignored (late target; the bus sees a double ready; logged only through err_count).
REQ-028 On entry to RESPOND:
- err_addr, err_write <= pending registers;
- err_irq <= 1;
- err_count increments, saturating at all-ones.
REQ-029 err_clear clears err_irq and err_count next cycle. Clear and a new timeout in the same cycle -> err_irq=1, err_count=1 (new event wins).
REQ-030 Strobe in the RESPOND cycle -> accepted as a new access (WAIT next, counter=0).

Reset
REQ-031 rst_n low SHALL asynchronously force:
- state=IDLE, counter=0;
- io_ready=0, io_read_data=0;
- err_irq=0, err_addr=0, err_write=0, err_count=0.
REQ-032 Reset during WAIT or RESPOND abandons the pending access with no response and no logging.
REQ-033 After release, the first rising edge SHALL evaluate IDLE normally.

Structure
REQ-034 A shared package iobus_pkg SHALL hold:
- the FSM state encoding (IDLE, WAIT, RESPOND);
- IOBUS_ADDR_W=32, IOBUS_DATA_W=32.
REQ-035 Counter width SHALL be derived as clog2(TIMEOUT+1).
REQ-036 The saturating error counter SHALL be a sub-module, iobus_sat_counter (parameter WIDTH; ports inc, clr, count).
REQ-037 All outputs SHALL be registered; there are no combinational input-to-output paths.

Verification (TIMEOUT=4, CNT_WIDTH=8)
REQ-038 Strobe, addr 32'hC000_0010, read, no target_ready -> io_ready=1 and io_read_data=32'hffffffff in cycle 4 only; err_addr=32'hC000_0010, err_write=0, err_irq=1, err_count=1.
REQ-039 Strobe, target_ready in cycle 2 -> io_ready never high; err_count unchanged.
REQ-040 Strobe, target_ready in cycle 3 (the timeout boundary) -> no response; target_ready in cycle 4 -> ignored, response already issued at cycle 4.
REQ-041 256 consecutive timed-out writes -> err_count=255, err_write=1; pulse err_clear -> err_count=0, err_irq=0.
REQ-042 err_clear asserted in the same cycle as a timeout -> err_irq=1, err_count=1.
REQ-043 rst_n low in cycle 2 of WAIT -> all outputs 0 immediately; no io_ready after release.
